// File: rtl/transpose_stream_if.sv
// Handshake bundle for transpose_stream: row-major input stream, transposed output stream.
interface transpose_stream_if #(
    parameter int N_BITS = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [N_BITS-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [N_BITS-1:0] out_data;
    logic                     out_last;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/transpose_stream.sv
// Streaming matrix transpose: SIZE_A x SIZE_B in row-major, SIZE_B x SIZE_A out row-major.
// TRANSPOSE_STREAM_DOUBLE_BUF_EN selects ping-pong buffers so fill and drain overlap.
module transpose_stream #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    transpose_stream_if.slave bus
);

`ifdef TRANSPOSE_STREAM_DOUBLE_BUF_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif
    localparam int MAT   = SIZE_A * SIZE_B;
    localparam int DEPTH = NBUF * MAT;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW    = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int CW    = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam logic [RW-1:0] RMAX = RW'(SIZE_A - 1);
    localparam logic [CW-1:0] CMAX = CW'(SIZE_B - 1);

    logic signed [N_BITS-1:0] mem [DEPTH];

    // r/c walk the input matrix; j (input row) / i (input column) walk it transposed
    logic [RW-1:0] r_q, j_q;
    logic [CW-1:0] c_q, i_q;
    logic          wsel, rsel;
    logic          in_rdy, out_vld;
    logic          wr_fire, rd_fire, wr_last, rd_last;

    function automatic logic [AW-1:0] addr(input logic sel, input logic [RW-1:0] row,
                                           input logic [CW-1:0] col);
        return AW'(sel) * AW'(MAT) + AW'(row) * AW'(SIZE_B) + AW'(col);
    endfunction

    assign wr_last = (r_q == RMAX) && (c_q == CMAX);
    assign rd_last = (i_q == CMAX) && (j_q == RMAX);
    assign wr_fire = bus.in_valid && in_rdy;
    assign rd_fire = out_vld && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
            c_q <= '0;
            i_q <= '0;
            j_q <= '0;
        end else begin
            if (wr_fire) begin
                if (c_q == CMAX) begin
                    c_q <= '0;
                    r_q <= (r_q == RMAX) ? '0 : r_q + 1'b1;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end
            if (rd_fire) begin
                if (j_q == RMAX) begin
                    j_q <= '0;
                    i_q <= (i_q == CMAX) ? '0 : i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end
        end
    end

    // Element storage carries no reset; only the sequencing state does
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[addr(wsel, r_q, c_q)] <= bus.in_data;
        end
    end

`ifdef TRANSPOSE_STREAM_DOUBLE_BUF_EN
    logic [1:0] full_q;
    logic       wsel_q, rsel_q;

    // Buffers fill and drain strictly in turn, so the write target is never the read target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 2'b00;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
        end else begin
            if (wr_fire && wr_last) begin
                full_q[wsel_q] <= 1'b1;
                wsel_q         <= ~wsel_q;
            end
            if (rd_fire && rd_last) begin
                full_q[rsel_q] <= 1'b0;
                rsel_q         <= ~rsel_q;
            end
        end
    end

    assign wsel     = wsel_q;
    assign rsel     = rsel_q;
    assign in_rdy   = !full_q[wsel_q];
    assign out_vld  = full_q[rsel_q];
    assign bus.busy = (|full_q) || (r_q != '0) || (c_q != '0);
`else
    typedef enum logic {FILL, DRAIN} state_t;
    state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state_q)
            FILL: begin
                in_rdy = 1'b1;
                if (bus.in_valid && wr_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_vld = 1'b1;
                if (bus.out_ready && rd_last) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign wsel     = 1'b0;
    assign rsel     = 1'b0;
    assign bus.busy = (state_q == DRAIN) || (r_q != '0) || (c_q != '0);
`endif

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_vld ? mem[addr(rsel, j_q, i_q)] : '0;
    assign bus.out_last  = out_vld && rd_last;

endmodule

// File: tb/tb_transpose_stream.sv
// Bench for transpose_stream: 2x3 instance for sequencing/backpressure/reset, 8x8 for signed extremes.
module tb_transpose_stream;
    localparam int A = 2;
    localparam int B = 3;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    transpose_stream_if #(.N_BITS(W)) bs ();
    transpose_stream_if #(.N_BITS(W)) bl ();

    transpose_stream #(.SIZE_A(A), .SIZE_B(B), .N_BITS(W)) dut_s (
        .clk(clk), .reset(reset), .bus(bs.slave));
    transpose_stream #(.SIZE_A(8), .SIZE_B(8), .N_BITS(W)) dut_l (
        .clk(clk), .reset(reset), .bus(bl.slave));

    int checks;
    int errors;
    int t_last_in, t_first_out, gaps;
    bit rdy_dropped;

    logic signed [W-1:0] mat[$];
    logic signed [W-1:0] in_q[$];
    logic signed [W-1:0] exp_q[$];
    bit                  last_q[$];
    logic signed [W-1:0] lmat[$];
    logic signed [W-1:0] got[$];

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: queue row-major input, then expect the transpose in row-major order
    task automatic load_mat(input int a, input int b);
        for (int r = 0; r < a; r++)
            for (int c = 0; c < b; c++)
                in_q.push_back(mat[r*b + c]);
        for (int i = 0; i < b; i++)
            for (int j = 0; j < a; j++) begin
                exp_q.push_back(mat[j*b + i]);
                last_q.push_back((i == b-1) && (j == a-1));
            end
    endtask

    task automatic rand_mat(input int n);
        mat.delete();
        for (int k = 0; k < n; k++) mat.push_back($urandom);
    endtask

    // mode 0: out_ready high, 1: toggling 1,0,1,0, 2: random
    task automatic run_s(input int mode, input int limit);
        logic          hold;
        logic          pl;
        logic [W-1:0]  pd;
        hold = 1'b0; pl = 1'b0; pd = '0;
        t_last_in = -1; t_first_out = -1; gaps = 0; rdy_dropped = 0;
        for (int n = 0; n < limit && (in_q.size() > 0 || exp_q.size() > 0); n++) begin
            if (mode == 0)      bs.out_ready = 1'b1;
            else if (mode == 1) bs.out_ready = (n % 2 == 0);
            else                bs.out_ready = 1'($urandom_range(0, 1));
            bs.in_valid = (in_q.size() > 0);
            bs.in_data  = (in_q.size() > 0) ? in_q[0] : '0;
            if (hold) begin
                chk_b("hold_valid", bs.out_valid, 1'b1);
                chk_d("hold_data", bs.out_data, pd);
                chk_b("hold_last", bs.out_last, pl);
            end
            if (bs.out_valid && t_first_out < 0) t_first_out = n;
            if (t_first_out >= 0 && !bs.out_valid && exp_q.size() > 0) gaps++;
            if (bs.in_valid && !bs.in_ready) rdy_dropped = 1;
            if (bs.out_valid && bs.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_b("extra_out", bs.out_valid, 1'b0);
                end else begin
                    chk_d("out_data", bs.out_data, exp_q.pop_front());
                    chk_b("out_last", bs.out_last, last_q.pop_front());
                end
            end
            hold = bs.out_valid && !bs.out_ready;
            pd   = bs.out_data;
            pl   = bs.out_last;
            if (bs.in_valid && bs.in_ready) begin
                if (in_q.size() == 1) t_last_in = n;
                void'(in_q.pop_front());
            end
            @(posedge clk); #1;
        end
        bs.in_valid  = 1'b0;
        bs.out_ready = 1'b0;
        chk_i("drained", in_q.size() + exp_q.size(), 0);
        in_q.delete(); exp_q.delete(); last_q.delete();
    endtask

    initial begin
        int k, n;
        checks = 0; errors = 0;
        reset = 1'b1;
        bs.in_valid = 1'b0; bs.in_data = '0; bs.out_ready = 1'b0;
        bl.in_valid = 1'b0; bl.in_data = '0; bl.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_b("rst_in_ready", bs.in_ready, 1'b1);
        chk_b("rst_out_valid", bs.out_valid, 1'b0);
        chk_b("rst_out_last", bs.out_last, 1'b0);
        chk_b("rst_busy", bs.busy, 1'b0);
        chk_d("rst_out_data", bs.out_data, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic 2x3, free-running output
        mat.delete();
        for (int v = 1; v <= 6; v++) mat.push_back(v);
        load_mat(A, B);
        run_s(0, 60);
        chk_i("t1_latency", t_first_out, t_last_in + 1);

        // Same matrix with toggling backpressure
        load_mat(A, B);
        run_s(1, 80);

        // Reset mid-fill discards the partial matrix
        for (int v = 0; v < 4; v++) begin
            bs.in_valid = 1'b1; bs.in_data = 100 + v;
            @(posedge clk); #1;
        end
        bs.in_valid = 1'b0;
        chk_b("t3_busy_pre", bs.busy, 1'b1);
        reset = 1'b1;
        #1;
        chk_b("t3_rst_ready", bs.in_ready, 1'b1);
        chk_b("t3_rst_busy", bs.busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        mat.delete();
        for (int v = 10; v <= 15; v++) mat.push_back(v);
        load_mat(A, B);
        run_s(0, 60);

        // Random data, random backpressure, back-to-back matrices
        for (int m = 0; m < 3; m++) begin
            rand_mat(A*B);
            load_mat(A, B);
        end
        run_s(2, 400);

`ifndef TRANSPOSE_STREAM_DOUBLE_BUF_EN
        // Input offered during drain must be refused and not disturb the buffer
        rand_mat(A*B);
        load_mat(A, B);
        bs.out_ready = 1'b0;
        for (int v = 0; v < A*B; v++) begin
            chk_b("t5_fill_rdy", bs.in_ready, 1'b1);
            bs.in_valid = 1'b1; bs.in_data = in_q.pop_front();
            @(posedge clk); #1;
        end
        for (int v = 0; v < 3; v++) begin
            bs.in_valid = 1'b1; bs.in_data = $urandom;
            chk_b("t5_drain_rdy", bs.in_ready, 1'b0);
            chk_b("t5_busy", bs.busy, 1'b1);
            chk_d("t5_head", bs.out_data, exp_q[0]);
            @(posedge clk); #1;
        end
        bs.in_valid = 1'b0;
        run_s(0, 60);
        chk_b("t5_idle", bs.busy, 1'b0);
`else
        // Two matrices streamed continuously through the ping-pong buffers
        rand_mat(A*B);
        load_mat(A, B);
        rand_mat(A*B);
        load_mat(A, B);
        run_s(0, 100);
        chk_b("t6_ready_held", rdy_dropped, 1'b0);
        chk_i("t6_gaps", gaps, 0);
        chk_b("t6_idle", bs.busy, 1'b0);
`endif

        // 8x8 with signed extremes in the corners
        lmat.delete();
        for (int v = 0; v < 64; v++) lmat.push_back($urandom);
        lmat[0]  = 32'sh80000000;
        lmat[7]  = -32'sd1;
        lmat[56] = 32'sd0;
        lmat[63] = 32'sh7fffffff;
        k = 0; n = 0;
        while (k < 64 && n < 200) begin
            bl.in_valid = 1'b1; bl.in_data = lmat[k];
            if (bl.in_ready) k++;
            @(posedge clk); #1;
            n++;
        end
        bl.in_valid = 1'b0;
        chk_i("l_fill", k, 64);
        got.delete(); n = 0;
        while (got.size() < 64 && n < 400) begin
            bl.out_ready = 1'($urandom_range(0, 1));
            if (bl.out_valid && bl.out_ready) begin
                chk_b("l_last", bl.out_last, got.size() == 63);
                got.push_back(bl.out_data);
            end
            @(posedge clk); #1;
            n++;
        end
        bl.out_ready = 1'b0;
        chk_i("l_count", got.size(), 64);
        while (got.size() < 64) got.push_back('x);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                chk_d("l_data", got[i*8 + j], lmat[j*8 + i]);
        chk_d("l_min_r0c0", got[0], 32'h80000000);
        chk_d("l_neg1_r0c7", got[56], 32'hffffffff);
        chk_d("l_zero_r7c0", got[7], 32'h00000000);
        chk_d("l_max_r7c7", got[63], 32'h7fffffff);
        chk_b("l_idle", bl.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
